run_pattern_detector: RTL and testbench



---
 rtl/run_pattern_detector.sv | 139 +++++++++++++
 tb/tb_run_pattern_detector.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/run_pattern_detector.sv
// Serial run-length detector: flags ZERO_LEN zeros followed by ONE_LEN ones,
// with qualified sampling and a saturating, clearable match counter.
module run_pattern_detector #(
    parameter int ZERO_LEN   = 2,
    parameter int ONE_LEN    = 3,
    parameter int EXACT_ZERO = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             x,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [1:0]       state
);
    localparam int ZW = $clog2(ZERO_LEN + 2);
    localparam int OW = $clog2(ONE_LEN + 1);

    localparam logic [ZW-1:0]    ZCNT_LEN  = ZW'(ZERO_LEN);
    localparam logic [ZW-1:0]    ZCNT_MAX  = ZW'(ZERO_LEN + 1);
    localparam logic [ZW-1:0]    ZCNT_ONE  = ZW'(1);
    localparam logic [OW-1:0]    OCNT_LAST = OW'(ONE_LEN - 1);
    localparam logic [OW-1:0]    OCNT_ONE  = OW'(1);
    localparam logic [CNT_W-1:0] CNT_ALL   = '1;

    generate
        if (ZERO_LEN < 1 || ONE_LEN < 1) begin : g_bad_params
            $error("run_pattern_detector: ZERO_LEN and ONE_LEN must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        ZERO = 2'd1,
        ONE  = 2'd2
    } state_t;

    state_t           st, st_nxt;
    logic [ZW-1:0]    zcnt, zcnt_nxt;
    logic [OW-1:0]    ocnt, ocnt_nxt;
    logic             hit;
    logic             qual;
    logic [CNT_W-1:0] cnt_base, cnt_nxt;
    logic             sat_base, sat_nxt;

    // zcnt stops one past ZERO_LEN so exact mode can tell an over-long run apart
    assign qual = (EXACT_ZERO != 0) ? (zcnt == ZCNT_LEN) : (zcnt >= ZCNT_LEN);

    always_comb begin
        st_nxt   = st;
        zcnt_nxt = zcnt;
        ocnt_nxt = ocnt;
        hit      = 1'b0;
        if (in_valid) begin
            case (st)
                HUNT: begin
                    if (!x) begin
                        zcnt_nxt = ZCNT_ONE;
                        st_nxt   = ZERO;
                    end
                end
                ZERO: begin
                    if (!x) begin
                        if (zcnt != ZCNT_MAX) zcnt_nxt = zcnt + ZCNT_ONE;
                    end else if (qual) begin
                        zcnt_nxt = '0;
                        if (ONE_LEN == 1) begin
                            hit    = 1'b1;
                            st_nxt = HUNT;
                        end else begin
                            ocnt_nxt = OCNT_ONE;
                            st_nxt   = ONE;
                        end
                    end else begin
                        zcnt_nxt = '0;
                        st_nxt   = HUNT;
                    end
                end
                ONE: begin
                    if (x) begin
                        if (ocnt == OCNT_LAST) begin
                            hit      = 1'b1;
                            ocnt_nxt = '0;
                            st_nxt   = HUNT;
                        end else begin
                            ocnt_nxt = ocnt + OCNT_ONE;
                        end
                    end else begin
                        // the aborting zero is the first bit of a fresh zero run
                        ocnt_nxt = '0;
                        zcnt_nxt = ZCNT_ONE;
                        st_nxt   = ZERO;
                    end
                end
                default: begin
                    zcnt_nxt = '0;
                    ocnt_nxt = '0;
                    st_nxt   = HUNT;
                end
            endcase
        end
    end

    // clear first, then count a match landing on the same edge
    always_comb begin
        cnt_base = clr ? '0 : match_cnt;
        sat_base = clr ? 1'b0 : cnt_sat;
        cnt_nxt  = cnt_base;
        sat_nxt  = sat_base;
        if (hit && cnt_base != CNT_ALL) begin
            cnt_nxt = cnt_base + 1'b1;
            if (cnt_nxt == CNT_ALL) sat_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= HUNT;
            zcnt      <= '0;
            ocnt      <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            st        <= st_nxt;
            zcnt      <= zcnt_nxt;
            ocnt      <= ocnt_nxt;
            match     <= hit;
            match_cnt <= cnt_nxt;
            cnt_sat   <= sat_nxt;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_run_pattern_detector.sv
// Bench for run_pattern_detector: three configurations share one stimulus stream
// and are compared every cycle against a history-based reference model.
module tb_run_pattern_detector;

    localparam int NI = 3;
    localparam int ZL   [NI] = '{2, 2, 1};
    localparam int OL   [NI] = '{3, 3, 1};
    localparam int EX   [NI] = '{0, 1, 0};
    localparam int CMAX [NI] = '{255, 255, 3};

    logic clk, rst_n, in_valid, x, clr;
    logic       m0, m1, m2;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    logic       s0, s1, s2;
    logic [1:0] st0, st1, st2;

    run_pattern_detector #(.ZERO_LEN(2), .ONE_LEN(3), .EXACT_ZERO(0), .CNT_W(8)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .clr(clr),
        .match(m0), .match_cnt(c0), .cnt_sat(s0), .state(st0));
    run_pattern_detector #(.ZERO_LEN(2), .ONE_LEN(3), .EXACT_ZERO(1), .CNT_W(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .clr(clr),
        .match(m1), .match_cnt(c1), .cnt_sat(s1), .state(st1));
    run_pattern_detector #(.ZERO_LEN(1), .ONE_LEN(1), .EXACT_ZERO(0), .CNT_W(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .clr(clr),
        .match(m2), .match_cnt(c2), .cnt_sat(s2), .state(st2));

    int m_o [NI];
    int c_o [NI];
    int s_o [NI];
    int st_o[NI];
    always_comb begin
        m_o[0] = int'(m0);  m_o[1] = int'(m1);  m_o[2] = int'(m2);
        c_o[0] = int'(c0);  c_o[1] = int'(c1);  c_o[2] = int'(c2);
        s_o[0] = int'(s0);  s_o[1] = int'(s1);  s_o[2] = int'(s2);
        st_o[0] = int'(st0); st_o[1] = int'(st1); st_o[2] = int'(st2);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: bits sampled since the last match/reset, newest in bit 0.
    logic [63:0] hist [NI];
    int hlen  [NI];
    int mcnt  [NI];
    int msat  [NI];
    int mhit  [NI];
    int mst   [NI];

    // k = trailing ones, z = zero run immediately before them
    function automatic void scan(input logic [63:0] h, input int len, output int k, output int z);
        int i;
        i = 0; k = 0; z = 0;
        while (i < len && h[i]) begin k++; i++; end
        while (i < len && !h[i]) begin z++; i++; end
    endfunction

    function automatic bit qual(input int idx, input int z);
        return (EX[idx] != 0) ? (z == ZL[idx]) : (z >= ZL[idx]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            hist[i] = '0; hlen[i] = 0; mcnt[i] = 0; msat[i] = 0; mhit[i] = 0; mst[i] = 0;
        end
    endtask

    task automatic model_edge(input bit v, input bit b, input bit c);
        int k, z, base, sbase;
        bit hit;
        for (int i = 0; i < NI; i++) begin
            hit = 1'b0;
            if (v) begin
                hist[i] = {hist[i][62:0], b};
                if (hlen[i] < 64) hlen[i]++;
                scan(hist[i], hlen[i], k, z);
                if (k == OL[i] && qual(i, z)) begin
                    hit = 1'b1;
                    hist[i] = '0;
                    hlen[i] = 0;
                end
            end
            mhit[i] = int'(hit);
            base  = c ? 0 : mcnt[i];
            sbase = c ? 0 : msat[i];
            if (hit && base != CMAX[i]) begin
                base++;
                if (base == CMAX[i]) sbase = 1;
            end
            mcnt[i] = base;
            msat[i] = sbase;
            scan(hist[i], hlen[i], k, z);
            if (hlen[i] == 0)                mst[i] = 0;
            else if (k == 0)                 mst[i] = 1;
            else if (z > 0 && qual(i, z))    mst[i] = 2;
            else                             mst[i] = 0;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("d%0d.match", i), m_o[i], mhit[i]);
            chk($sformatf("d%0d.match_cnt", i), c_o[i], mcnt[i]);
            chk($sformatf("d%0d.cnt_sat", i), s_o[i], msat[i]);
            chk($sformatf("d%0d.state", i), st_o[i], mst[i]);
        end
    endtask

    task automatic step(input bit v, input bit b, input bit c);
        in_valid = v; x = b; clr = c;
        @(posedge clk);
        model_edge(v, b, c);
        @(negedge clk);
        compare_all();
    endtask

    // '0'/'1' = valid bit, '-' = stall cycle
    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++)
            step(s[i] != "-", s[i] == "1", 1'b0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; x = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        feed("00111");
        feed("000111");
        feed("001001111");
        feed("001---11");
        feed("0011");
        async_reset();
        feed("1");

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) async_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
        end

        // saturate the 2-bit counter, then clear on the same edge as a match
        step(1'b1, 1'b1, 1'b1);
        feed("01010101");
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        feed("1--1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
